buffer_arbiter: RTL and testbench
=================================

# buffer_arbiter

Ownership controller for the 64-byte endpoint data buffer. It shares the buffer between the AHB-Lite slave and the USB RX and TX packet engines, drives the buffer's `buffer_reserved` and access strobes, and sequences protocol-controller clears. It blocks overflow and underflow accesses, flags them, and stalls the AHB side until that side holds the buffer and the access is legal.

## Interface
Parameters:
- `DEPTH`, 64, buffer capacity in bytes; occupancy width is 7 bits.
- `WDOG_CYCLES`, 255, AHB ownership idle timeout in cycles (used only with the macro).

Ports:
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `clear_req`  in  1  protocol controller requests buffer flush
- `ahb_req`  in  1  AHB slave requests buffer ownership (level)
- `ahb_store`  in  1  AHB write request; `ahb_get` in 1 AHB read request (4 bytes)
- `ahb_data_size`  in  2  bytes-1 of the AHB write
- `rx_active`  in  1  RX packet in progress (level); `rx_store`  in  1  RX byte valid
- `tx_active`  in  1  TX packet in progress (level); `tx_get`  in  1  TX byte request
- `buffer_occupancy`  in  7  current byte count from the buffer
- `buffer_reserved`  out  1  high while the AHB owns the buffer
- `clear`, `store_tx_data`, `get_rx_data`, `store_rx_packet_data`, `get_tx_packet_data`  out  1 each  gated strobes to the buffer
- `ahb_grant`  out  1  AHB owns the buffer; `ahb_stall`  out  1  AHB access is held off
- `rx_overflow`, `tx_underrun`  out  1 each  sticky error flags; cleared by `clear`

## Operation
- States: IDLE, AHB_OWN, RX_OWN, TX_OWN, FLUSH. The state is registered.
- Transitions from IDLE, by priority: `clear_req` -> FLUSH; `rx_active` -> RX_OWN; `tx_active` -> TX_OWN; `ahb_req` -> AHB_OWN.
- An owner keeps the buffer until its level request deasserts. Then the state returns to IDLE and re-arbitration takes one cycle. There is no direct owner-to-owner transition.
- `clear_req` in any state goes to FLUSH. FLUSH lasts exactly one cycle, then returns to IDLE.
- Strobes are the raw request ANDed with the current state:
  - `store_rx_packet_data = rx_store & RX_OWN & (occupancy < DEPTH)`
  - `get_tx_packet_data = tx_get & TX_OWN & (occupancy != 0)`
  - `store_tx_data = ahb_store & AHB_OWN & (occupancy + data_size + 1 <= DEPTH)`, computed at 8 bits
  - `get_rx_data = ahb_get & AHB_OWN & (occupancy >= 4)`
- An RX store blocked by a full buffer sets `rx_overflow`. A TX get on an empty buffer sets `tx_underrun`. A blocked access never reaches the buffer.
- `ahb_stall = (ahb_store | ahb_get) & ~(AHB_OWN & access legal)`.
- `ahb_grant` and `buffer_reserved` equal (state == AHB_OWN).
- If `ahb_store` and `ahb_get` are asserted together, the store wins and the get is stalled.
- RX and TX strobes that arrive outside their own state are ignored and set no flag.

## Timing
- Reset values: state IDLE; all outputs 0; flags 0.
- Grant latency: request asserted in cycle N -> owner state and grant in cycle N+1.
- Strobes are combinational from registered state and live inputs, so they act in the same cycle as the request.
- `clear` is high for exactly the single FLUSH cycle. Flags clear on the following edge.
- Release: the request drops in cycle N -> IDLE in cycle N+1 -> new owner in cycle N+2.
- Reset asserted mid-operation: immediate return to IDLE; all strobes low asynchronously.

## Configuration
- `BUFFER_ARB_WDOG_EN` defined:
  - A counter runs while in AHB_OWN with neither `ahb_store` nor `ahb_get` active.
  - When it reaches `WDOG_CYCLES`, the state is forced to IDLE, even if `ahb_req` is still high.
  - The counter resets on any AHB access or on leaving AHB_OWN.
- Not defined: no counter; AHB ownership is unbounded.

## Structure
- Package `usb_buf_pkg`: state enum `arb_state_t`, constant `BUF_DEPTH = 64`, constant `RX_WORD_BYTES = 4`.
- Sub-module `arb_watchdog`: a loadable up-counter with clear, terminal-count output and a `WDOG_CYCLES` parameter. It is instantiated only under the macro.

## Test plan
- Reset, then `ahb_req` = 1 -> `ahb_grant` = 1 one cycle later; `buffer_reserved` = 1; `ahb_store` with size 3 at occupancy 60 -> `store_tx_data` pulses.
- Occupancy 62, `ahb_store` with size 3 -> `store_tx_data` = 0 and `ahb_stall` = 1 until occupancy is 60.
- `rx_active` and `ahb_req` assert in the same cycle -> RX_OWN; AHB stays stalled; `rx_active` drops -> AHB_OWN two cycles later.
- RX_OWN at occupancy 64 with `rx_store` -> no store strobe; `rx_overflow` = 1; `clear_req` -> `clear` for one cycle; flag = 0 afterwards.
- TX_OWN at occupancy 0 with `tx_get` -> `tx_underrun` = 1 and no get strobe.
- With the macro defined and `WDOG_CYCLES` = 8: AHB_OWN idle for 8 cycles -> IDLE, `ahb_grant` = 0.

Source files
------------

// File: rtl/usb_buf_pkg.sv
// Shared types and constants for the endpoint buffer arbiter.
// Owner-state encoding, buffer geometry and the AHB write-fit helper.
package usb_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AHB_OWN = 3'd1,
        ST_RX_OWN  = 3'd2,
        ST_TX_OWN  = 3'd3,
        ST_FLUSH   = 3'd4
    } arb_state_t;

    localparam int unsigned BUF_DEPTH     = 64;
    localparam int unsigned RX_WORD_BYTES = 4;

    // Evaluated at 8 bits so a full buffer plus a 4-byte write cannot wrap.
    function automatic logic ahb_store_fits(input logic [6:0] occ,
                                            input logic [1:0] size_m1,
                                            input logic [7:0] depth);
        return (({1'b0, occ} + {6'b0, size_m1} + 8'd1) <= depth);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Loadable idle up-counter with clear and terminal-count flag; used to
// bound AHB buffer ownership when BUFFER_ARB_WDOG_EN is defined.
module arb_watchdog #(
    parameter int unsigned WDOG_CYCLES = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    // Terminal count fires on the WDOG_CYCLES-th consecutive enabled cycle.
    assign tc    = en & (count_r == CNT_W'(WDOG_CYCLES - 1));
    assign count = count_r;

    // Idle cycle counter; saturates at terminal count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && !tc) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Ownership controller for the 64-byte endpoint buffer shared by AHB, RX and TX.
// Optional AHB idle-ownership watchdog: define BUFFER_ARB_WDOG_EN.
module buffer_arbiter
    import usb_buf_pkg::*;
#(
    parameter int unsigned DEPTH       = BUF_DEPTH,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear_req,
    input  logic       ahb_req,
    input  logic       ahb_store,
    input  logic       ahb_get,
    input  logic [1:0] ahb_data_size,
    input  logic       rx_active,
    input  logic       rx_store,
    input  logic       tx_active,
    input  logic       tx_get,
    input  logic [6:0] buffer_occupancy,
    output logic       buffer_reserved,
    output logic       clear,
    output logic       store_tx_data,
    output logic       get_rx_data,
    output logic       store_rx_packet_data,
    output logic       get_tx_packet_data,
    output logic       ahb_grant,
    output logic       ahb_stall,
    output logic       rx_overflow,
    output logic       tx_underrun
);

    arb_state_t state_r;
    arb_state_t next_s;
    logic       rx_overflow_r;
    logic       tx_underrun_r;

    logic [7:0] depth8_s;
    logic       ahb_own_s, rx_own_s, tx_own_s, flush_s;
    logic       rx_room_s, tx_avail_s, store_fit_s, get_avail_s;
    logic       rx_block_s, tx_block_s;
    logic       ahb_legal_s;
    logic       wdog_tc_s;

    assign depth8_s    = 8'(DEPTH);
    assign ahb_own_s   = (state_r == ST_AHB_OWN);
    assign rx_own_s    = (state_r == ST_RX_OWN);
    assign tx_own_s    = (state_r == ST_TX_OWN);
    assign flush_s     = (state_r == ST_FLUSH);

    assign rx_room_s   = ({1'b0, buffer_occupancy} < depth8_s);
    assign tx_avail_s  = (buffer_occupancy != 7'd0);
    assign store_fit_s = ahb_store_fits(buffer_occupancy, ahb_data_size, depth8_s);
    assign get_avail_s = (buffer_occupancy >= 7'(RX_WORD_BYTES));

    assign store_rx_packet_data = rx_store & rx_own_s & rx_room_s;
    assign get_tx_packet_data   = tx_get & tx_own_s & tx_avail_s;
    assign rx_block_s           = rx_store & rx_own_s & ~rx_room_s;
    assign tx_block_s           = tx_get & tx_own_s & ~tx_avail_s;

    // A simultaneous store takes the cycle, so the get is never legal alongside it.
    assign store_tx_data = ahb_store & ahb_own_s & store_fit_s;
    assign get_rx_data   = ahb_get & ~ahb_store & ahb_own_s & get_avail_s;
    assign ahb_legal_s   = ahb_store ? (store_fit_s & ~ahb_get) : get_avail_s;
    assign ahb_stall     = (ahb_store | ahb_get) & ~(ahb_own_s & ahb_legal_s);

    assign ahb_grant       = ahb_own_s;
    assign buffer_reserved = ahb_own_s;
    assign clear           = flush_s;
    assign rx_overflow     = rx_overflow_r;
    assign tx_underrun     = tx_underrun_r;

`ifdef BUFFER_ARB_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_count_s;
    logic              wdog_idle_s;

    assign wdog_idle_s = ahb_own_s & ~ahb_store & ~ahb_get;

    arb_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES),
        .CNT_W      (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (~wdog_idle_s),
        .load    (1'b0),
        .load_val({WDOG_W{1'b0}}),
        .en      (wdog_idle_s),
        .count   (wdog_count_s),
        .tc      (wdog_tc_s)
    );
`else
    assign wdog_tc_s = 1'b0;
`endif

    // Next-owner selection; owners always pass back through IDLE.
    always_comb begin
        next_s = state_r;
        if (clear_req && (state_r != ST_FLUSH)) begin
            next_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_active)      next_s = ST_RX_OWN;
                    else if (tx_active) next_s = ST_TX_OWN;
                    else if (ahb_req)   next_s = ST_AHB_OWN;
                    else                next_s = ST_IDLE;
                end
                ST_AHB_OWN: begin
                    if (!ahb_req || wdog_tc_s) next_s = ST_IDLE;
                    else                       next_s = ST_AHB_OWN;
                end
                ST_RX_OWN: begin
                    if (!rx_active) next_s = ST_IDLE;
                    else            next_s = ST_RX_OWN;
                end
                ST_TX_OWN: begin
                    if (!tx_active) next_s = ST_IDLE;
                    else            next_s = ST_TX_OWN;
                end
                ST_FLUSH: next_s = ST_IDLE;
                default:  next_s = ST_IDLE;
            endcase
        end
    end

    // State register and sticky error flags, wiped at the end of a flush.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= ST_IDLE;
            rx_overflow_r <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            state_r <= next_s;
            if (flush_s) begin
                rx_overflow_r <= 1'b0;
                tx_underrun_r <= 1'b0;
            end else begin
                if (rx_block_s) rx_overflow_r <= 1'b1;
                if (tx_block_s) tx_underrun_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Scoreboard bench for buffer_arbiter: directed scenarios then randomized
// traffic, each cycle's expected outputs predicted by an ownership model.
module tb_buffer_arbiter;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear_req = 1'b0, ahb_req = 1'b0, ahb_store = 1'b0, ahb_get = 1'b0;
    logic [1:0] ahb_data_size = 2'd0;
    logic       rx_active = 1'b0, rx_store = 1'b0, tx_active = 1'b0, tx_get = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       buffer_reserved, clear, store_tx_data, get_rx_data;
    logic       store_rx_packet_data, get_tx_packet_data, ahb_grant, ahb_stall;
    logic       rx_overflow, tx_underrun;

    buffer_arbiter dut (
        .clk(clk), .n_rst(n_rst), .clear_req(clear_req), .ahb_req(ahb_req),
        .ahb_store(ahb_store), .ahb_get(ahb_get), .ahb_data_size(ahb_data_size),
        .rx_active(rx_active), .rx_store(rx_store), .tx_active(tx_active),
        .tx_get(tx_get), .buffer_occupancy(buffer_occupancy),
        .buffer_reserved(buffer_reserved), .clear(clear),
        .store_tx_data(store_tx_data), .get_rx_data(get_rx_data),
        .store_rx_packet_data(store_rx_packet_data),
        .get_tx_packet_data(get_tx_packet_data), .ahb_grant(ahb_grant),
        .ahb_stall(ahb_stall), .rx_overflow(rx_overflow), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n_v;
        logic       clr;
        logic       areq;
        logic       st;
        logic       gt;
        logic [1:0] sz;
        logic       rxa;
        logic       rxs;
        logic       txa;
        logic       txg;
        logic [6:0] occ;
    } stim_t;

    typedef enum {FREE, OWN_AHB, OWN_RX, OWN_TX, FLUSHING} owner_e;

    owner_e     own = FREE;
    bit         m_rxo = 1'b0, m_txu = 1'b0;
    logic [9:0] exp_q[$];
    stim_t      cur;
    int         n_checks = 0, n_pass = 0;
    string      names[10] = '{"tx_underrun", "rx_overflow", "ahb_stall", "get_tx",
                              "store_rx", "get_rx", "store_tx", "clear",
                              "buffer_reserved", "ahb_grant"};

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for this cycle, straight from the ownership rules.
    function automatic logic [9:0] predict(input stim_t s);
        int  occ  = int'(s.occ);
        bit  ahb  = (own == OWN_AHB);
        bit  stx  = s.st && ahb && (occ + int'(s.sz) + 1 <= 64);
        bit  grx  = s.gt && !s.st && ahb && (occ >= 4);
        bit  srx  = s.rxs && own == OWN_RX && occ < 64;
        bit  gtx  = s.txg && own == OWN_TX && occ > 0;
        bit  stal = (s.st && !stx) || (s.gt && !grx);
        return {ahb, ahb, own == FLUSHING, stx, grx, srx, gtx, stal, m_rxo, m_txu};
    endfunction

    // Advance the model across the clock edge that ends this cycle.
    function automatic void advance(input stim_t s);
        if (own == FLUSHING) begin
            m_rxo = 1'b0;
            m_txu = 1'b0;
        end else begin
            if (s.rxs && own == OWN_RX && s.occ >= 7'd64) m_rxo = 1'b1;
            if (s.txg && own == OWN_TX && s.occ == 7'd0)  m_txu = 1'b1;
        end
        if (own == FLUSHING)                              own = FREE;
        else if (s.clr)                                   own = FLUSHING;
        else if (own == FREE)                             own = s.rxa ? OWN_RX : s.txa ? OWN_TX : s.areq ? OWN_AHB : FREE;
        else if (own == OWN_AHB && !s.areq)               own = FREE;
        else if (own == OWN_RX && !s.rxa)                 own = FREE;
        else if (own == OWN_TX && !s.txa)                 own = FREE;
    endfunction

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        n_rst = s.rst_n_v; clear_req = s.clr; ahb_req = s.areq; ahb_store = s.st;
        ahb_get = s.gt; ahb_data_size = s.sz; rx_active = s.rxa; rx_store = s.rxs;
        tx_active = s.txa; tx_get = s.txg; buffer_occupancy = s.occ;
        if (!s.rst_n_v) begin
            own = FREE; m_rxo = 1'b0; m_txu = 1'b0;
        end
        exp_q.push_back(predict(s));
        if (s.rst_n_v) advance(s);
    endtask

    task automatic repeat_apply(input int n);
        for (int i = 0; i < n; i++) apply(cur);
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        logic [9:0] act, exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {ahb_grant, buffer_reserved, clear, store_tx_data, get_rx_data,
                       store_rx_packet_data, get_tx_packet_data, ahb_stall,
                       rx_overflow, tx_underrun};
                for (int i = 0; i < 10; i++) check(names[i], act[i], exp[i]);
            end
        end
    end

    initial begin
        int occs[10] = '{0, 1, 3, 4, 5, 60, 61, 62, 63, 64};
        cur = '0;
        repeat_apply(3);
        cur.rst_n_v = 1'b1;

        // AHB grant then a write that exactly fills the buffer.
        cur.areq = 1'b1; cur.occ = 7'd60;      repeat_apply(1);
        cur.st = 1'b1; cur.sz = 2'd3;          repeat_apply(1);
        cur.occ = 7'd62;                       repeat_apply(3);
        cur.occ = 7'd60;                       repeat_apply(1);
        cur.st = 1'b0; cur.gt = 1'b1; cur.occ = 7'd4; repeat_apply(1);
        cur.st = 1'b1;                         repeat_apply(1);
        cur.st = 1'b0; cur.gt = 1'b0; cur.areq = 1'b0; repeat_apply(1);

        // RX wins a simultaneous request; AHB owns two cycles after release.
        cur.rxa = 1'b1; cur.areq = 1'b1; cur.st = 1'b1; cur.sz = 2'd0; cur.occ = 7'd10;
        repeat_apply(3);
        cur.rxa = 1'b0;                        repeat_apply(3);
        cur.areq = 1'b0; cur.st = 1'b0;        repeat_apply(1);

        // Overflow on a full buffer, then flush clears the flag.
        cur.rxa = 1'b1; cur.occ = 7'd64;       repeat_apply(1);
        cur.rxs = 1'b1;                        repeat_apply(1);
        cur.rxs = 1'b0;                        repeat_apply(1);
        cur.clr = 1'b1;                        repeat_apply(1);
        cur.clr = 1'b0;                        repeat_apply(3);
        cur.rxa = 1'b0;                        repeat_apply(1);

        // Underrun on an empty buffer; stray RX strobe is ignored.
        cur.txa = 1'b1; cur.occ = 7'd0;        repeat_apply(2);
        cur.txg = 1'b1; cur.rxs = 1'b1;        repeat_apply(1);
        cur.txg = 1'b0; cur.rxs = 1'b0;        repeat_apply(2);
        cur.txa = 1'b0;                        repeat_apply(1);

        // Mid-operation reset while TX owns with a pending strobe.
        cur.txa = 1'b1; cur.txg = 1'b1; cur.occ = 7'd5; repeat_apply(3);
        cur.rst_n_v = 1'b0;                    repeat_apply(1);
        cur.rst_n_v = 1'b1; cur = '0; cur.rst_n_v = 1'b1; repeat_apply(1);

        // Randomized traffic with sticky levels and boundary-biased occupancy.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) cur.areq = ~cur.areq;
            if ($urandom_range(7) == 0) cur.rxa  = ~cur.rxa;
            if ($urandom_range(7) == 0) cur.txa  = ~cur.txa;
            cur.clr     = ($urandom_range(39) == 0);
            cur.rst_n_v = ($urandom_range(249) != 0);
            cur.st  = $urandom_range(1);
            cur.gt  = $urandom_range(1);
            cur.rxs = $urandom_range(1);
            cur.txg = $urandom_range(1);
            cur.sz  = 2'($urandom_range(3));
            if ($urandom_range(2) == 0) cur.occ = 7'($urandom_range(64));
            else                        cur.occ = 7'(occs[$urandom_range(9)]);
            apply(cur);
        end

        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
